// File: rtl/tinyml_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tinyml_pkg : shared FSM encoding and int32 clamp limits for TinyML MACs   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package tinyml_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int ACC_W_DEFAULT = 40;

  localparam logic signed [ACC_W_DEFAULT-1:0] INT32_MAX =
    {{(ACC_W_DEFAULT-32){1'b0}}, 32'h7FFF_FFFF};
  localparam logic signed [ACC_W_DEFAULT-1:0] INT32_MIN =
    {{(ACC_W_DEFAULT-32){1'b1}}, 32'h8000_0000};

endpackage
`default_nettype wire

// File: rtl/vedic16_x_16_sc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vedic16_x_16_sc : combinational signed 16x16 multiplier (vedic 8x8 tiles) |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module vedic16_x_16_sc (
  input  logic signed [15:0] a_i,
  input  logic signed [15:0] b_i,
  output logic signed [31:0] p_o
);

  logic [15:0] w_mag_a;
  logic [15:0] w_mag_b;
  logic [15:0] w_pp_ll;
  logic [15:0] w_pp_lh;
  logic [15:0] w_pp_hl;
  logic [15:0] w_pp_hh;
  logic [31:0] w_mag_p;
  logic        w_neg;

  // Magnitudes fit in 16 unsigned bits even for -32768, so the tiles stay 8x8.
  always_comb begin
    w_mag_a = a_i[15] ? 16'(-a_i) : 16'(a_i);
    w_mag_b = b_i[15] ? 16'(-b_i) : 16'(b_i);
    w_neg   = a_i[15] ^ b_i[15];
    w_pp_ll = {8'd0, w_mag_a[7:0]}  * {8'd0, w_mag_b[7:0]};
    w_pp_lh = {8'd0, w_mag_a[7:0]}  * {8'd0, w_mag_b[15:8]};
    w_pp_hl = {8'd0, w_mag_a[15:8]} * {8'd0, w_mag_b[7:0]};
    w_pp_hh = {8'd0, w_mag_a[15:8]} * {8'd0, w_mag_b[15:8]};
    w_mag_p = {w_pp_hh, w_pp_ll}
            + {8'd0, w_pp_lh, 8'd0}
            + {8'd0, w_pp_hl, 8'd0};
    p_o     = w_neg ? 32'(-w_mag_p) : 32'(w_mag_p);
  end

endmodule
`default_nettype wire

// File: rtl/vmac16_dot_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vmac16_dot_seq : pipelined signed 16-bit dot product, int32-saturated     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module vmac16_dot_seq
  import tinyml_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    op_valid,
  input  logic signed [15:0]      op_a,
  input  logic signed [15:0]      op_b,
  output logic                    op_ready,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             result,
  output logic                    sat
);

  localparam logic signed [ACC_W-1:0] c_acc_max = ACC_W'(INT32_MAX);
  localparam logic signed [ACC_W-1:0] c_acc_min = ACC_W'(INT32_MIN);

  state_t                   state_q, state_d;
  logic [LEN_W-1:0]         rem_q, rem_d;
  logic signed [15:0]       a1_q, a1_d;
  logic signed [15:0]       b1_q, b1_d;
  logic                     v1_q, v1_d;
  logic                     v2_q, v2_d;
  logic signed [31:0]       prod_q;
  logic signed [31:0]       w_prod;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [31:0]              result_q, result_d;
  logic                     sat_q, sat_d;
  logic                     w_hs;
  logic                     w_clip_hi;
  logic                     w_clip_lo;
  logic [31:0]              w_clamped;

  vedic16_x_16_sc u_mult (
    .a_i (a1_q),
    .b_i (b1_q),
    .p_o (w_prod)
  );

  always_comb begin
    w_clip_hi = (acc_q > c_acc_max);
    w_clip_lo = (acc_q < c_acc_min);
    w_clamped = w_clip_hi ? 32'h7FFF_FFFF :
                w_clip_lo ? 32'h8000_0000 : acc_q[31:0];
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    result_d = result_q;
    sat_d    = sat_q;
    op_ready = (state_q == ST_RUN) && (rem_q != '0);
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    w_hs     = op_valid && op_ready;
    a1_d     = w_hs ? op_a : a1_q;
    b1_d     = w_hs ? op_b : b1_q;
    v1_d     = w_hs;
    v2_d     = v1_q;
    acc_d    = v2_q ? (acc_q + ACC_W'(prod_q)) : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d = len;
          acc_d = '0;
          sat_d = 1'b0;
          if (len == '0) begin
            result_d = '0;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (w_hs) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // acc is final once both pipeline stages have emptied.
        if (!v1_q && !v2_q) begin
          result_d = w_clamped;
          sat_d    = w_clip_hi || w_clip_lo;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      a1_q     <= '0;
      b1_q     <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      prod_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      a1_q     <= a1_d;
      b1_q     <= b1_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      prod_q   <= w_prod;
      acc_q    <= acc_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end

  assign result = result_q;
  assign sat    = sat_q;

endmodule
`default_nettype wire
